fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, range 2..16.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction presented when the queue is empty.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  branch flush from fetch; discards all queued entries.
REQ-006 push_valid_i  input  1  fetch offers {pc_i, instr_i} this cycle.
REQ-007 pc_i  input  32  PC of the offered instruction.
REQ-008 instr_i  input  32  offered instruction word.
REQ-009 push_ready_o  output  1  queue can accept; drives the fetch-stage enable.
REQ-010 pop_ready_i  input  1  decode consumes the head this cycle (not stalled).
REQ-011 pop_valid_o  output  1  head entry is valid.
REQ-012 pc_o  output  32  head PC; 0 when empty.
REQ-013 instr_o  output  32  head instruction; NOP_INSTR when empty.
REQ-014 count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage SHALL be DEPTH entries of {pc, instr} with a write pointer, a read pointer (log2(DEPTH) bits, natural wrap) and an occupancy counter.
REQ-016 push_ready_o SHALL equal (count_o != DEPTH); it SHALL NOT depend on pop_ready_i or flush_i combinationally.
REQ-017 A push occurs when push_valid_i && push_ready_o && !flush_i: write entry at wptr, wptr+1.
REQ-018 A pop occurs when pop_valid_o && pop_ready_i && !flush_i: rptr+1.
REQ-019 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-020 pop_valid_o SHALL equal (count_o != 0); pc_o/instr_o are a combinational read of the entry at rptr, gated to 0/NOP_INSTR when empty.
REQ-021 Latency: an entry pushed at edge k SHALL appear on pop_valid_o/pc_o/instr_o after edge k (no same-cycle bypass).
REQ-022 flush_i SHALL have priority: at the next edge wptr=rptr=count=0; the push and pop of that cycle are discarded.
REQ-023 Entries SHALL leave in push order; pointer wrap from DEPTH-1 to 0 SHALL NOT corrupt order.
REQ-024 Push while full (push_ready_o=0) SHALL be ignored, with no state change; pop while empty SHALL be ignored.

Reset
REQ-025 On reset_n low, asynchronously: wptr=rptr=count=0, pop_valid_o=0, pc_o=0, instr_o=NOP_INSTR, push_ready_o=1.
REQ-026 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-027 After reset_n deasserts, the first push SHALL be accepted on the first active edge.

Configuration
REQ-028 Macro FETCH_QUEUE_FLUSH_CNT_EN, when defined, SHALL add output flush_cnt_o [15:0], reset to 0, incremented on every cycle with flush_i=1, saturating at 16'hFFFF.
REQ-029 Without FETCH_QUEUE_FLUSH_CNT_EN, flush_cnt_o SHALL NOT exist and behaviour is otherwise identical.

Verification
REQ-030 Reset, then idle -> pop_valid_o=0, instr_o=32'h00000013, pc_o=0, count_o=0, push_ready_o=1.
REQ-031 Push PCs 0x0,0x4,0x8,0xC with pop_ready_i=0 -> count_o=4, push_ready_o=0; a 5th push (0x10) is ignored; then pop 4 -> PCs out 0x0,0x4,0x8,0xC in order.
REQ-032 Continuous push and pop every cycle for 10 PCs from 0x100 -> count_o stays 1 after the first edge, outputs 0x100..0x124 in order across pointer wrap.
REQ-033 Fill with 3 entries, assert flush_i with push_valid_i=1 and pop_ready_i=1 -> next cycle count_o=0, pop_valid_o=0, pushed entry absent.
REQ-034 Assert reset_n=0 mid-stream with 2 entries queued -> outputs at reset values immediately, without waiting for a clock edge.
REQ-035 With FETCH_QUEUE_FLUSH_CNT_EN defined, pulse flush_i 3 times -> flush_cnt_o=3; hold flush_i for 70000 cycles -> flush_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// The slave modport is the queue side and the master modport is the fetch/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          push_valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   instr_i;
  logic          push_ready_o;
  logic          pop_ready_i;
  logic          pop_valid_o;
  logic [31:0]   pc_o;
  logic [31:0]   instr_o;
  logic [CW-1:0] count_o;

  modport master (
    output flush_i, push_valid_i, pc_i, instr_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pc_o, instr_o, count_o
  );

  modport slave (
    input  flush_i, push_valid_i, pc_i, instr_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pc_o, instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular {pc, instr} queue between fetch and decode, with flush and no same-cycle bypass.
// Defining FETCH_QUEUE_FLUSH_CNT_EN adds a saturating flush counter output flush_cnt_o.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_queue_if.slave bus
`ifdef FETCH_QUEUE_FLUSH_CNT_EN
  ,
  output logic [15:0]  flush_cnt_o
`endif
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Ready/valid come only from the occupancy register, never from pop_ready_i or flush_i.
  assign bus.push_ready_o = (count_q != FULL);
  assign bus.pop_valid_o  = (count_q != '0);
  assign bus.pc_o         = bus.pop_valid_o ? pc_mem_q[rptr_q]    : 32'h0;
  assign bus.instr_o      = bus.pop_valid_o ? instr_mem_q[rptr_q] : NOP_INSTR;
  assign bus.count_o      = count_q;

  assign do_push = bus.push_valid_i && bus.push_ready_o && !bus.flush_i;
  assign do_pop  = bus.pop_valid_o  && bus.pop_ready_i  && !bus.flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is left uncleared on reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wptr_q]    <= bus.pc_i;
      instr_mem_q[wptr_q] <= bus.instr_i;
    end
  end

`ifdef FETCH_QUEUE_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
    end else if (bus.flush_i && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random push/pop/flush traffic.
// With FETCH_QUEUE_FLUSH_CNT_EN defined it also checks the saturating flush counter.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
`ifdef FETCH_QUEUE_FLUSH_CNT_EN
  logic [15:0] flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_QUEUE_FLUSH_CNT_EN
    ,
    .flush_cnt_o (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  bit   popped;
  int   exp_flush;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares occupancy/flags every cycle and pops the scoreboard on every DUT pop.
  always @(negedge clk) begin
    ent_t e;
    popped = 1'b0;
    if (reset_n) begin
      chk("count", 32'(bus.count_o), 32'(sb.size()));
      chk("push_ready", 32'(bus.push_ready_o), 32'(sb.size() != DEPTH));
      chk("pop_valid", 32'(bus.pop_valid_o), 32'(sb.size() != 0));
      if (sb.size() == 0) begin
        chk("empty_pc", bus.pc_o, 32'h0);
        chk("empty_instr", bus.instr_o, NOP);
      end
      if (bus.pop_valid_o && bus.pop_ready_i && !bus.flush_i) begin
        if (sb.size() == 0) begin
          chk("pop_from_empty", 32'(bus.pop_valid_o), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("head_pc", bus.pc_o, e.pc);
          chk("head_instr", bus.instr_o, e.instr);
          popped = 1'b1;
        end
      end
`ifdef FETCH_QUEUE_FLUSH_CNT_EN
      chk("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
`endif
    end
  end

  // Reference model: queue contents change at the clock edge; a pop already left via the monitor.
  always @(posedge clk) begin
    if (!reset_n) begin
      sb.delete();
      exp_flush = 0;
    end else if (bus.flush_i) begin
      sb.delete();
      if (exp_flush < 65535) exp_flush++;
    end else if (bus.push_valid_i && (sb.size() + int'(popped)) < DEPTH) begin
      sb.push_back('{pc: bus.pc_i, instr: bus.instr_i});
    end
  end

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic pr, input logic fl);
    bus.push_valid_i = pv;
    bus.pc_i         = pc;
    bus.instr_i      = instr;
    bus.pop_ready_i  = pr;
    bus.flush_i      = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  initial begin
    reset_n          = 1'b0;
    exp_flush        = 0;
    bus.push_valid_i = 1'b0;
    bus.pc_i         = '0;
    bus.instr_i      = '0;
    bus.pop_ready_i  = 1'b0;
    bus.flush_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Idle after reset
    drive(0, 0, 0, 0, 0);
    chk("rst_pop_valid", 32'(bus.pop_valid_o), 32'h0);
    chk("rst_instr", bus.instr_o, 32'h0000_0013);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_count", 32'(bus.count_o), 32'h0);
    chk("rst_push_ready", 32'(bus.push_ready_o), 32'h1);

    // Fill to full, overflow push ignored, then drain in order
    for (int i = 0; i < 4; i++) drive(1, 32'(4*i), mk_instr(32'(4*i)), 0, 0);
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_push_ready", 32'(bus.push_ready_o), 32'h0);
    drive(1, 32'h10, mk_instr(32'h10), 0, 0);
    chk("overflow_count", 32'(bus.count_o), 32'd4);
    chk("overflow_head", bus.pc_o, 32'h0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    chk("drained_count", 32'(bus.count_o), 32'd0);

    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h100 + 32'(4*i), mk_instr(32'h100 + 32'(4*i)), 1, 0);
      chk("stream_count", 32'(bus.count_o), 32'd1);
      chk("stream_head", bus.pc_o, 32'h100 + 32'(4*i));
    end
    drive(0, 0, 0, 1, 0);

    // Flush wins over a simultaneous push and pop
    for (int i = 0; i < 3; i++) drive(1, 32'h200 + 32'(4*i), mk_instr(32'h200 + 32'(4*i)), 0, 0);
    drive(1, 32'h300, mk_instr(32'h300), 1, 1);
    chk("flush_count", 32'(bus.count_o), 32'd0);
    chk("flush_pop_valid", 32'(bus.pop_valid_o), 32'h0);
    drive(0, 0, 0, 0, 0);
    chk("flush_absent", 32'(bus.count_o), 32'd0);

    // Asynchronous reset mid-stream
    drive(1, 32'h400, mk_instr(32'h400), 0, 0);
    drive(1, 32'h404, mk_instr(32'h404), 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pop_valid", 32'(bus.pop_valid_o), 32'h0);
    chk("arst_pc", bus.pc_o, 32'h0);
    chk("arst_instr", bus.instr_o, NOP);
    chk("arst_count", 32'(bus.count_o), 32'h0);
    chk("arst_push_ready", 32'(bus.push_ready_o), 32'h1);
    sb.delete();
    exp_flush = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1, 32'h500, mk_instr(32'h500), 0, 0);
    chk("first_push_count", 32'(bus.count_o), 32'd1);
    chk("first_push_pc", bus.pc_o, 32'h500);

`ifdef FETCH_QUEUE_FLUSH_CNT_EN
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
    end
    chk("flush_cnt_3", 32'(flush_cnt), 32'd3);
    repeat (70000) drive(0, 0, 0, 0, 1);
    chk("flush_cnt_sat", 32'(flush_cnt), 32'h0000_FFFF);
    drive(0, 0, 0, 0, 0);
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      drive(logic'(($urandom % 4) != 0), rpc, $urandom,
            logic'(($urandom % 3) != 0), logic'(($urandom % 40) == 0));
    end
    drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
